// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, 16x oversampling with 3-sample majority vote,
// baud rate chosen by Baud_set and latched at the start edge.
module uart_byte_rx #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       uart_rx,
  input  logic [2:0] Baud_set,
  output logic [7:0] Data,
  output logic       Rx_done,
  output logic       Frame_err
);

  localparam int DIV_MAX = CLK_FREQ_HZ / (9600 * 16);
  localparam int DW      = (DIV_MAX < 2) ? 1 : $clog2(DIV_MAX);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  function automatic int baud_div(input int code);
    int baud;
    case (code)
      1:       baud = 19200;
      2:       baud = 38400;
      3:       baud = 57600;
      4:       baud = 115200;
      default: baud = 9600;
    endcase
    return CLK_FREQ_HZ / (baud * 16);
  endfunction

  // Terminal count (DIV-1) of the oversample divider for each Baud_set code
  logic [DW-1:0] div_last [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_div_lut
      assign div_last[gi] = DW'(baud_div(gi) - 1);
    end
  endgenerate

  logic          sync1_reg;
  logic          rx_s_reg;
  logic          rx_s_d_reg;
  state_t        state_reg;
  logic [2:0]    baud_reg;
  logic [DW-1:0] div_cnt_reg;
  logic [3:0]    tick_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic [1:0]    samp_reg;
  logic [7:0]    shreg_reg;

  logic start_edge;
  logic tick;
  logic vote;
  logic mid_bit;
  logic bit_end;

  assign start_edge = rx_s_d_reg & ~rx_s_reg;
  assign tick       = (state_reg != IDLE) && (div_cnt_reg == div_last[baud_reg]);
  // Third sample is the live synchronised line at tick 9
  assign vote       = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s_reg) |
                      (samp_reg[1] & rx_s_reg);
  assign mid_bit    = tick && (tick_cnt_reg == 4'd9);
  assign bit_end    = tick && (tick_cnt_reg == 4'd15);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_reg  <= 1'b1;
      rx_s_reg   <= 1'b1;
      rx_s_d_reg <= 1'b1;
    end else begin
      sync1_reg  <= uart_rx;
      rx_s_reg   <= sync1_reg;
      rx_s_d_reg <= rx_s_reg;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= IDLE;
      baud_reg     <= 3'd0;
      div_cnt_reg  <= '0;
      tick_cnt_reg <= 4'd0;
      bit_cnt_reg  <= 3'd0;
      samp_reg     <= 2'b00;
      shreg_reg    <= 8'h00;
      Data         <= 8'h00;
      Rx_done      <= 1'b0;
      Frame_err    <= 1'b0;
    end else begin
      Rx_done   <= 1'b0;
      Frame_err <= 1'b0;

      if (state_reg == IDLE || tick) div_cnt_reg <= '0;
      else                           div_cnt_reg <= div_cnt_reg + DW'(1);

      if (tick) begin
        tick_cnt_reg <= tick_cnt_reg + 4'd1;
        if (tick_cnt_reg == 4'd7) samp_reg[0] <= rx_s_reg;
        if (tick_cnt_reg == 4'd8) samp_reg[1] <= rx_s_reg;
      end

      case (state_reg)
        IDLE: begin
          tick_cnt_reg <= 4'd0;
          if (start_edge) begin
            state_reg <= START;
            baud_reg  <= Baud_set;
          end
        end
        START: begin
          if (mid_bit && vote) begin
            state_reg <= IDLE;
          end else if (bit_end) begin
            state_reg   <= DATA;
            bit_cnt_reg <= 3'd0;
          end
        end
        DATA: begin
          if (mid_bit) shreg_reg <= {vote, shreg_reg[7:1]};
          if (bit_end) begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) state_reg <= STOP;
          end
        end
        STOP: begin
          // Leave mid-stop-bit so a back-to-back start edge is not missed
          if (mid_bit) begin
            if (vote) begin
              Data    <= shreg_reg;
              Rx_done <= 1'b1;
            end else begin
              Frame_err <= 1'b1;
            end
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: framed bytes at several rates, glitch, framing error,
// mid-frame reset and +/-2.5% rate offset.
`timescale 1ns/1ps
module tb_uart_byte_rx;

  // 9.216 MHz divides every supported baud rate exactly (DIV = 60,30,15,10,5)
  localparam int  CLK_HZ = 9_216_000;
  localparam real B9600  = 1.0e9 / 9600.0;
  localparam real B19200 = 1.0e9 / 19200.0;
  localparam real B38400 = 1.0e9 / 38400.0;
  localparam real B57600 = 1.0e9 / 57600.0;
  localparam real B115K  = 1.0e9 / 115200.0;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [2:0] Baud_set = 3'd0;
  logic [7:0] Data;
  logic       Rx_done;
  logic       Frame_err;

  int n_vec = 0;
  int n_err = 0;

  int         done_cnt = 0;
  int         fe_cnt = 0;
  int         overlap_cnt = 0;
  int         long_cnt = 0;
  logic       prev_done = 1'b0;
  logic       prev_fe = 1'b0;
  logic [7:0] cap [64];

  uart_byte_rx #(.CLK_FREQ_HZ(CLK_HZ)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .uart_rx  (uart_rx),
    .Baud_set (Baud_set),
    .Data     (Data),
    .Rx_done  (Rx_done),
    .Frame_err(Frame_err)
  );

  always #54.253 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Rx_done) begin
      if (done_cnt < 64) cap[done_cnt] <= Data;
      done_cnt <= done_cnt + 1;
      $display("[%0t] rx byte 0x%02h", $time, Data);
    end
    if (Frame_err) begin
      fe_cnt <= fe_cnt + 1;
      $display("[%0t] frame error strobe", $time);
    end
    if (Rx_done && Frame_err) overlap_cnt <= overlap_cnt + 1;
    if ((Rx_done && prev_done) || (Frame_err && prev_fe)) long_cnt <= long_cnt + 1;
    prev_done <= Rx_done;
    prev_fe   <= Frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input real bit_ns, input logic stop_bit);
    $display("[%0t] tx byte 0x%02h stop=%0b bit=%0.1fns", $time, d, stop_bit, bit_ns);
    uart_rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      #(bit_ns);
    end
    uart_rx = stop_bit;
    #(bit_ns);
    uart_rx = 1'b1;
  endtask

  initial begin
    int d0;
    int f0;
    logic [7:0] partial;

    repeat (5) @(posedge Clk);
    #1;
    chk("rst_data", Data, 8'h00);
    chk("rst_done", Rx_done, 1'b0);
    chk("rst_ferr", Frame_err, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (10) @(posedge Clk);

    // 0x55 at 9600
    Baud_set = 3'd0;
    d0 = done_cnt; f0 = fe_cnt;
    send_frame(8'h55, B9600, 1'b1);
    #(B9600);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_data", Data, 8'h55);
    chk("t1_ferr_cnt", fe_cnt - f0, 0);

    // Back-to-back frames at 115200
    Baud_set = 3'd4;
    d0 = done_cnt;
    send_frame(8'hA3, B115K, 1'b1);
    send_frame(8'h00, B115K, 1'b1);
    send_frame(8'hFF, B115K, 1'b1);
    #(2.0 * B115K);
    chk("t2_done_cnt", done_cnt - d0, 3);
    chk("t2_byte0", cap[d0], 8'hA3);
    chk("t2_byte1", cap[d0+1], 8'hFF & 8'h00);
    chk("t2_byte2", cap[d0+2], 8'hFF);

    // 3 us glitch is rejected as a false start, then a real byte still arrives
    d0 = done_cnt; f0 = fe_cnt;
    uart_rx = 1'b0;
    #3000;
    uart_rx = 1'b1;
    #(3.0 * B115K);
    chk("t3_glitch_done", done_cnt - d0, 0);
    chk("t3_glitch_ferr", fe_cnt - f0, 0);
    send_frame(8'h5A, B115K, 1'b1);
    #(B115K);
    chk("t3_after_done", done_cnt - d0, 1);
    chk("t3_after_data", Data, 8'h5A);

    // Low stop bit at 38400
    Baud_set = 3'd2;
    d0 = done_cnt; f0 = fe_cnt;
    send_frame(8'h3C, B38400, 1'b0);
    #(2.0 * B38400);
    chk("t4_ferr_cnt", fe_cnt - f0, 1);
    chk("t4_done_cnt", done_cnt - d0, 0);
    chk("t4_data_kept", Data, 8'h5A);

    // Reset during bit 4 of 0x81, then a clean 0x7E
    Baud_set = 3'd1;
    d0 = done_cnt; f0 = fe_cnt;
    partial = 8'h81;
    uart_rx = 1'b0;
    #(B19200);
    for (int i = 0; i < 5; i++) begin
      uart_rx = partial[i];
      if (i < 4) #(B19200);
    end
    #(B19200 / 2.0);
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("t5_rst_data", Data, 8'h00);
    chk("t5_rst_done", Rx_done, 1'b0);
    chk("t5_rst_ferr", Frame_err, 1'b0);
    uart_rx = 1'b1;
    #(B19200 / 4.0);
    @(negedge Clk);
    Reset_n = 1'b1;
    #(2.0 * B19200);
    send_frame(8'h7E, B19200, 1'b1);
    #(B19200);
    chk("t5_done_cnt", done_cnt - d0, 1);
    chk("t5_data", Data, 8'h7E);
    chk("t5_ferr_cnt", fe_cnt - f0, 0);

    // Transmitter 2.5% fast, then 2.5% slow, at 57600
    Baud_set = 3'd3;
    d0 = done_cnt;
    send_frame(8'h96, B57600 / 1.025, 1'b1);
    #(B57600);
    chk("t6_fast_done", done_cnt - d0, 1);
    chk("t6_fast_data", Data, 8'h96);
    d0 = done_cnt;
    Reset_n = 1'b1;
    send_frame(8'h96, B57600 * 1.025, 1'b1);
    #(B57600);
    chk("t6_slow_done", done_cnt - d0, 1);
    chk("t6_slow_data", Data, 8'h96);

    // Unused code 7 falls back to 9600
    Baud_set = 3'd7;
    d0 = done_cnt;
    send_frame(8'h12, B9600, 1'b1);
    #(B9600);
    chk("t7_done", done_cnt - d0, 1);
    chk("t7_data", Data, 8'h12);

    chk("total_done", done_cnt, 9);
    chk("total_ferr", fe_cnt, 1);
    chk("strobe_overlap", overlap_cnt, 0);
    chk("strobe_width", long_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
